// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Initiator-side load/store unit for a word-addressed data memory.
//   It accepts byte-addressed MIPS loads and stores over a valid/ready
//   handshake. Sub-word loads use lane extraction. Sub-word stores use a
//   read-modify-write sequence. Illegal, misaligned and out-of-range
//   requests are answered with an error response and never reach memory.
//
// Ports
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   req_valid    : request present
//   req_ready    : unit idle and able to accept a request
//   req_op       : bit3 = store; LB/LH/LW/LBU/LHU/SB/SH/SW encodings
//   req_addr     : byte address
//   req_wdata    : store data (SB uses [7:0], SH uses [15:0])
//   resp_valid   : one-cycle completion pulse
//   resp_rdata   : extended load result, 0 for stores and errors
//   resp_err     : error flag, qualified by resp_valid
//   mem_addr     : memory word index
//   mem_wdata    : full word written to memory
//   mem_enaR     : memory read enable
//   mem_enaW     : memory write enable
//   mem_rdata    : combinational memory read data
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_WORDS = 1024,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_enaR,
  output logic        mem_enaW,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(ADDR_WORDS);
  localparam logic [3:0]  OP_SW      = 4'b1010;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WR     = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [2:0]  op_r;        // op without the store bit; the state encodes it
  logic [1:0]  boff_r;      // byte offset inside the word
  logic [15:0] wdata_r;     // sub-word store data kept for the merge
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic [31:0] resp_rdata_r;
  logic        resp_err_r;
  logic        accept_err_s;

  // Bit position of the addressed lane inside the 32-bit word.
  function automatic logic [4:0] lane_shift(input logic [1:0] boff, input logic half);
    logic [4:0] sh;
    if (BIG_ENDIAN) begin
      sh = half ? {~boff[1], 4'b0000} : {~boff, 3'b000};
    end else begin
      sh = half ? {boff[1], 4'b0000} : {boff, 3'b000};
    end
    return sh;
  endfunction

  // Pick the addressed lane out of a memory word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  op,
                                               input logic [1:0]  boff);
    logic [31:0] sh_word;
    logic [31:0] res;
    sh_word = word >> lane_shift(boff, op[0]);
    case (op[1:0])
      2'b00:   res = op[2] ? {24'h00_0000, sh_word[7:0]}
                           : {{24{sh_word[7]}}, sh_word[7:0]};
      2'b01:   res = op[2] ? {16'h0000, sh_word[15:0]}
                           : {{16{sh_word[15]}}, sh_word[15:0]};
      2'b10:   res = word;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Replace the addressed byte/halfword of the old word with store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [15:0] wd,
                                             input logic        half,
                                             input logic [1:0]  boff);
    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] data;
    sh   = lane_shift(boff, half);
    mask = half ? 32'h0000_FFFF : 32'h0000_00FF;
    data = half ? {16'h0000, wd} : {24'h00_0000, wd[7:0]};
    return (old_word & ~(mask << sh)) | (data << sh);
  endfunction

  // Request validity: legal opcode, natural alignment, word index in range.
  function automatic logic req_error(input logic [3:0] op, input logic [31:0] addr);
    logic legal;
    logic misaligned;
    logic out_of_range;
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
      4'b1000, 4'b1001, 4'b1010: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
    misaligned   = ((op[1:0] == 2'b01) && addr[0]) ||
                   ((op[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    out_of_range = ({2'b00, addr[31:2]} >= ADDR_LIMIT);
    return !legal || misaligned || out_of_range;
  endfunction

  assign accept_err_s = req_error(req_op, req_addr);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; errors skip memory and go straight to RESP.
  always_comb begin
    next_state_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (!req_valid) begin
          next_state_s = S_IDLE;
        end else if (accept_err_s) begin
          next_state_s = S_RESP;
        end else if (!req_op[3]) begin
          next_state_s = S_RD;
        end else if (req_op[1:0] == 2'b10) begin
          next_state_s = S_WR;
        end else begin
          next_state_s = S_RMW_RD;
        end
      end
      S_RD:     next_state_s = S_RESP;
      S_WR:     next_state_s = S_RESP;
      S_RMW_RD: next_state_s = S_RMW_WR;
      S_RMW_WR: next_state_s = S_RESP;
      S_RESP:   next_state_s = S_IDLE;
      default:  next_state_s = S_IDLE;
    endcase
  end

  // Handshake and memory strobes decoded from the state register only, so
  // they drop as soon as reset asserts and are never both high.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_enaR   = 1'b0;
    mem_enaW   = 1'b0;
    case (state_r)
      S_IDLE:   req_ready  = 1'b1;
      S_RD:     mem_enaR   = 1'b1;
      S_WR:     mem_enaW   = 1'b1;
      S_RMW_RD: mem_enaR   = 1'b1;
      S_RMW_WR: mem_enaW   = 1'b1;
      S_RESP:   resp_valid = 1'b1;
      default:  req_ready  = 1'b0;
    endcase
  end

  // Request latch, write-word build and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r         <= 3'b000;
      boff_r       <= 2'b00;
      wdata_r      <= 16'h0000;
      mem_addr_r   <= 32'h0000_0000;
      mem_wdata_r  <= 32'h0000_0000;
      resp_rdata_r <= 32'h0000_0000;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid) begin
            op_r       <= req_op[2:0];
            boff_r     <= req_addr[1:0];
            wdata_r    <= req_wdata[15:0];
            mem_addr_r <= {2'b00, req_addr[31:2]};
            if (req_op == OP_SW) begin
              mem_wdata_r <= req_wdata;
            end
            if (accept_err_s) begin
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 32'h0000_0000;
            end
          end
        end
        S_RD: begin
          resp_err_r   <= 1'b0;
          resp_rdata_r <= load_extract(mem_rdata, op_r, boff_r);
        end
        S_RMW_RD: begin
          // Old word arrives combinationally; the merged word is written next cycle.
          mem_wdata_r <= lane_merge(mem_rdata, wdata_r, op_r[0], boff_r);
        end
        S_WR, S_RMW_WR: begin
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 32'h0000_0000;
        end
        default: begin
          resp_err_r <= resp_err_r;
        end
      endcase
    end
  end

  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store unit that drives the word-addressed data memory (1024 x 32, combinational read, write on rising clk) on behalf of the CPU datapath.
- Accepts byte-addressed load/store requests over a valid/ready handshake and performs the matching memory transactions.
- Handles MIPS sub-word accesses: LB/LBU/LH/LHU by lane extraction, SB/SH by read-modify-write.
- Signals misalignment and out-of-range errors without touching memory.

Parameters:
- ADDR_WORDS, 1024, number of 32-bit words in the data memory; word indices at or above this are out of range.
- BIG_ENDIAN, 1, byte lane order; 1 means byte offset 0 is bits [31:24]. 0 means byte offset 0 is bits [7:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_op  in  4  bit3 = store. Loads: 0000 LB, 0001 LH, 0010 LW, 0100 LBU, 0101 LHU. Stores: 1000 SB, 1001 SH, 1010 SW. All other codes are illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; SB uses bits [7:0], SH uses bits [15:0].
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, extended as the op requires; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid; set for illegal op, misalignment, or out of range.
- mem_addr  out  32  word index = {2'b00, req_addr[31:2]}.
- mem_wdata  out  32  full word to write.
- mem_enaR  out  1  memory read enable.
- mem_enaW  out  1  memory write enable.
- mem_rdata  in  32  memory read data, combinational from mem_addr while mem_enaR = 1.

Behaviour:
- Reset (async, rst_n = 0):
  - State = IDLE.
  - resp_valid, resp_err, mem_enaR, mem_enaW = 0; resp_rdata, mem_addr, mem_wdata = 0.
  - mem_enaR/mem_enaW decode from registered state, so they drop immediately when reset asserts.
  - Reset mid read-modify-write aborts it; no partial write occurs unless the write edge has already passed.
- Acceptance:
  - A request is accepted on the rising edge where req_valid & req_ready; call that cycle T.
  - op, address and data are latched at acceptance.
- Error checks at acceptance:
  - illegal op;
  - LH/LHU/SH with addr[0] = 1;
  - LW/SW with addr[1:0] != 0;
  - addr[31:2] >= ADDR_WORDS.
  - Any error -> RESP at T+1 with resp_err = 1, rdata = 0, and no mem_enaR or mem_enaW at any point.
- States:
  - IDLE: req_ready = 1.
  - RD: mem_enaR = 1; mem_rdata is captured at the end of the cycle.
  - WR: mem_enaW = 1, mem_wdata = the full word.
  - RMW_RD: mem_enaR = 1; the old word is captured.
  - RMW_WR: mem_enaW = 1; mem_wdata = old word with the target lane replaced.
  - RESP: resp_valid = 1; next state is IDLE.
- Transitions and latency (resp_valid cycle):
  - Load: IDLE -> RD -> RESP, resp_valid at T+2.
  - SW: IDLE -> WR -> RESP, resp_valid at T+2; memory updated at the end of T+1.
  - SB/SH: IDLE -> RMW_RD -> RMW_WR -> RESP, resp_valid at T+3.
  - Back-to-back requests: the next request is accepted no earlier than the cycle after RESP.
- mem_enaR and mem_enaW are never both 1. Both are 0 in IDLE and RESP, so the memory's input-port refresh runs.
- mem_addr holds the latched word index from the cycle after acceptance until IDLE.
- Lane selection, BIG_ENDIAN = 1:
  - byte offset k occupies bits [31-8k -: 8];
  - halfword offset 0 -> [31:16], offset 2 -> [15:0].
- Extension:
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is unmodified.
- Memory-mapped I/O words (1022 input, 1023 output) are ordinary addresses to this unit; no special casing.
- resp_rdata and resp_err hold their value until the next RESP.

Test Plan:
- Reset, then SW addr 0x0000_0010 data 0xDEADBEEF -> mem_enaW = 1 at T+1 with mem_addr = 4, mem_wdata = 0xDEADBEEF; resp_valid at T+2, err = 0.
- LB addr 0x11 after the above -> RD at T+1 with mem_addr = 4; resp_rdata = 0xFFFFFFAD at T+2. LBU at the same address -> 0x000000AD.
- SB addr 0x13 data 0x55 over word 0xDEADBEEF -> RMW_RD at T+1, RMW_WR at T+2 with mem_wdata = 0xDEADBE55, resp_valid at T+3. A following LW 0x10 returns 0xDEADBE55.
- LH addr 0x11 -> resp_valid at T+1, err = 1, rdata = 0, mem_enaR never asserted. SW addr 0x1000 (word 1024) -> out-of-range error with the same timing.
- SW addr 0xFFC (word 1023) data 0x0000_00A5 -> mem_addr = 1023, mem_enaW = 1; the memory's output port shows 0xA5 after the write.
- Assert rst_n = 0 during RMW_RD of SH 0x20 -> mem_enaR drops immediately, no write occurs, req_ready = 1 after reset is released, and word 8 is unchanged.
